ckpt_monitor: RTL
=================

Name: ckpt_monitor

Overview:
- Synthesizable self-checking run monitor for the 16-bit cache/DMA CPU.
- Watches the CPU's num_inst, output_port and is_halted signals against a loadable table of instruction-count checkpoints, and counts cycles against a cycle budget.
- Reports pass/fail/no-result per checkpoint; optionally accumulates cache hit/miss statistics.
- Sits beside the cpu and memory instances; intended for FPGA bring-up, where no simulator testbench exists.

Parameters:
- WORD_SIZE, 16, width of num_inst, output_port and the table fields.
- NUM_TEST, 56, number of checkpoint entries.
- IDX_W, 6, index width; must satisfy 2**IDX_W >= NUM_TEST.
- MAX_CYCLES, 10000, cycle budget before timeout.
- CYC_W, 16, width of the cycle and statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe; honoured only in IDLE.
- cfg_idx  in  IDX_W  table entry index.
- cfg_num_inst  in  WORD_SIZE  checkpoint instruction count.
- cfg_ans  in  WORD_SIZE  expected output_port value.
- start  in  1  one-cycle pulse: IDLE->RUN.
- num_inst  in  WORD_SIZE  CPU retired-instruction count.
- output_port  in  WORD_SIZE  CPU WWD output.
- is_halted  in  1  CPU halted.
- cache_hit  in  1  one-cycle pulse per cache hit.
- cache_miss  in  1  one-cycle pulse per cache miss.
- done  out  1  run finished (DONE state).
- all_pass  out  1  done && pass_count == NUM_TEST.
- fail  out  1  a checkpoint mismatched.
- timeout  out  1  cycle budget exhausted.
- first_fail_idx  out  IDX_W  index of the failing checkpoint.
- fail_value  out  WORD_SIZE  output_port value at the failure.
- pass_count  out  IDX_W+1  number of passed checkpoints.
- num_clock  out  CYC_W  RUN cycles counted.
- hit_count  out  CYC_W  cache hits.
- miss_count  out  CYC_W  cache misses.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; ptr=0; every output 0; entry_seen=0, entry_ok=0. Table contents are not reset. Reset mid-run aborts immediately; the table is kept.
- Table entries must be loaded in strictly ascending cfg_num_inst order. An unsorted table gives undefined results; this is not checked.
- IDLE:
  - cfg_we writes table[cfg_idx].
  - cfg_idx >= NUM_TEST is ignored.
  - start -> RUN; num_clock and the statistics counters clear on entry.
- RUN, every cycle:
  - num_clock increments.
  - If num_inst == table[ptr].num_inst: entry_seen=1.
    - output_port == ans: entry_ok=1.
    - Otherwise: fail=1, first_fail_idx=ptr, fail_value=output_port, go to DONE next cycle. This matches an every-cycle compare that stops on the first mismatch.
  - If num_inst > table[ptr].num_inst: retire the entry.
    - pass_count += entry_ok.
    - ptr++ and clear entry_seen/entry_ok.
    - An entry retired with entry_seen=0 is a no-result entry (not passed, not failed).
    - Retiring entry NUM_TEST-1 parks ptr; no further compares.
  - is_halted=1: retire the current entry (pass_count += entry_ok), then DONE.
    - If a mismatch occurs in the same cycle, fail takes precedence and the entry is not counted.
  - num_clock reaching MAX_CYCLES-1: timeout=1, DONE. Lower priority than fail and halt in the same cycle.
- DONE:
  - done=1; all outputs frozen.
  - start is ignored; only reset returns the block to IDLE.
- start while in RUN or DONE: ignored.
- Latency:
  - compare result visible one cycle after the sampled inputs;
  - done asserts one cycle after the terminating event.
- Counters saturate at all-ones; they never wrap.

Optional Feature:
- CKPT_CACHE_STATS_EN defined:
  - hit_count/miss_count increment in RUN on cache_hit/cache_miss pulses;
  - a simultaneous hit and miss increments both.
- CKPT_CACHE_STATS_EN undefined: hit_count and miss_count are tied to 0 and no counter registers are generated.

Decomposition:
- Package ckpt_monitor_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WORD_SIZE, NUM_TEST, MAX_CYCLES constants;
  - the table entry field widths.
- One sub-module, ckpt_table: NUM_TEST x 2*WORD_SIZE register file with one write port and one async read port at ptr.

Test Plan:
- Load entries {3:0x0000, 5:0x0002}; start; drive num_inst 0..6 with output_port=0x0000, then 0x0002 at num_inst 5; is_halted at num_inst 6 -> done=1, pass_count=2, all_pass=1 (NUM_TEST=2).
- Same table; output_port=0x0001 at num_inst 5 -> fail=1, first_fail_idx=1, fail_value=0x0001, done one cycle later, pass_count=1.
- num_inst jumps 2->4 (skips checkpoint 3) -> entry 0 no-result; pass_count excludes it; all_pass=0 at halt.
- Never halt, MAX_CYCLES=20 -> timeout=1, done=1, num_clock=20.
- With CKPT_CACHE_STATS_EN: 7 hit pulses and 3 miss pulses, including one simultaneous pair -> hit_count=7, miss_count=3. Without the macro: both read 0.
- Assert reset_n=0 mid-RUN at num_clock=8 -> all outputs 0 asynchronously; start again re-runs against the retained table with an identical result.

Source files
------------

// File: rtl/ckpt_monitor_pkg.sv
// Shared types and defaults for the checkpoint run monitor.
package ckpt_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ckptState_t;

    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_NUM_TEST   = 56;
    localparam int DEF_IDX_W      = 6;
    localparam int DEF_MAX_CYCLES = 10000;
    localparam int DEF_CYC_W      = 16;

    // Each table entry holds {checkpoint num_inst, expected output_port}.
    localparam int ENTRY_FIELDS = 2;

    function automatic int entryWidth(input int wordSize);
        return ENTRY_FIELDS * wordSize;
    endfunction

endpackage

// File: rtl/ckpt_monitor_table.sv
// Checkpoint table: NUM_TEST entries, one write port, one async read port.
module ckpt_table
    import ckpt_monitor_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_TEST  = DEF_NUM_TEST,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     wrIdx,
    input  logic [WORD_SIZE-1:0] wrNumInst,
    input  logic [WORD_SIZE-1:0] wrAns,
    input  logic [IDX_W-1:0]     rdIdx,
    output logic [WORD_SIZE-1:0] rdNumInst,
    output logic [WORD_SIZE-1:0] rdAns
);

    localparam int EW = entryWidth(WORD_SIZE);

    logic [EW-1:0] mem [NUM_TEST];
    logic [EW-1:0] rdEntry;

    // Full-width index decode, so out-of-range indices never alias a real entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TEST; i++) begin
            if (we && wrIdx == IDX_W'(i)) mem[i] <= {wrNumInst, wrAns};
        end
    end

    always_comb begin
        rdEntry = '0;
        for (int i = 0; i < NUM_TEST; i++) begin
            if (rdIdx == IDX_W'(i)) rdEntry = mem[i];
        end
    end

    assign {rdNumInst, rdAns} = rdEntry;

endmodule

// File: rtl/ckpt_monitor.sv
// Run monitor comparing CPU progress against a checkpoint table and a cycle budget.
// Define CKPT_CACHE_STATS_EN to build the cache hit/miss counters.
module ckpt_monitor
    import ckpt_monitor_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int NUM_TEST   = DEF_NUM_TEST,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CYC_W      = DEF_CYC_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [WORD_SIZE-1:0] cfg_num_inst,
    input  logic [WORD_SIZE-1:0] cfg_ans,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    input  logic                 cache_hit,
    input  logic                 cache_miss,
    output logic                 done,
    output logic                 all_pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [WORD_SIZE-1:0] fail_value,
    output logic [IDX_W:0]       pass_count,
    output logic [CYC_W-1:0]     num_clock,
    output logic [CYC_W-1:0]     hit_count,
    output logic [CYC_W-1:0]     miss_count,
    output logic [1:0]           dbgState,
    output logic                 dbgEntrySeen
);

    ckptState_t state, nextState;

    logic [IDX_W-1:0]     ptr;
    logic                 parked;
    logic                 entrySeen, entryOk;
    logic [WORD_SIZE-1:0] entryNumInst, entryAns;
    logic                 eqHit, gtHit, failEv, retireEv, okNow, timeoutEv;

    ckpt_table #(
        .WORD_SIZE(WORD_SIZE),
        .NUM_TEST (NUM_TEST),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk      (clk),
        .we       (cfg_we && state == IDLE),
        .wrIdx    (cfg_idx),
        .wrNumInst(cfg_num_inst),
        .wrAns    (cfg_ans),
        .rdIdx    (ptr),
        .rdNumInst(entryNumInst),
        .rdAns    (entryAns)
    );

    // Once the last entry is retired (parked) no further compares happen.
    assign eqHit     = !parked && (num_inst == entryNumInst);
    assign gtHit     = !parked && (num_inst > entryNumInst);
    assign failEv    = eqHit && (output_port != entryAns);
    assign okNow     = entryOk || (eqHit && output_port == entryAns);
    assign retireEv  = !parked && (gtHit || is_halted);
    assign timeoutEv = (num_clock == CYC_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (failEv || is_halted || timeoutEv) nextState = DONE;
            default: nextState = state;
        endcase
    end

    always_comb begin
        done         = (state == DONE);
        all_pass     = done && (pass_count == (IDX_W+1)'(NUM_TEST));
        dbgState     = state;
        dbgEntrySeen = entrySeen;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr            <= '0;
            parked         <= 1'b0;
            entrySeen      <= 1'b0;
            entryOk        <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            first_fail_idx <= '0;
            fail_value     <= '0;
            pass_count     <= '0;
            num_clock      <= '0;
        end else if (state == IDLE && start) begin
            num_clock <= '0;
        end else if (state == RUN) begin
            if (num_clock != '1) num_clock <= num_clock + CYC_W'(1);
            // Priority within a cycle: mismatch, then retirement, then a plain match.
            if (failEv) begin
                fail           <= 1'b1;
                first_fail_idx <= ptr;
                fail_value     <= output_port;
            end else if (retireEv) begin
                if (okNow && pass_count != '1) pass_count <= pass_count + (IDX_W+1)'(1);
                if (ptr == IDX_W'(NUM_TEST - 1)) parked <= 1'b1;
                else                              ptr    <= ptr + IDX_W'(1);
                entrySeen <= 1'b0;
                entryOk   <= 1'b0;
            end else if (eqHit) begin
                entrySeen <= 1'b1;
                entryOk   <= 1'b1;
            end
            if (!failEv && !is_halted && timeoutEv) timeout <= 1'b1;
        end
    end

`ifdef CKPT_CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && start) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == RUN) begin
            if (cache_hit && hit_count != '1)   hit_count  <= hit_count + CYC_W'(1);
            if (cache_miss && miss_count != '1) miss_count <= miss_count + CYC_W'(1);
        end
    end
`else
    logic unusedStats;
    assign unusedStats = cache_hit ^ cache_miss;
    assign hit_count   = '0;
    assign miss_count  = '0;
`endif

endmodule
